// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war rope controller: state encodings,
// default widths and the rope centre helper.
package tug_pkg;

    localparam int unsigned SCORE_W_DFLT = 32'd4;

    localparam logic [1:0] HOLDOFF = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] WIN     = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLDOFF = HOLDOFF,
        ST_ARMED   = ARMED,
        ST_RELEASE = RELEASE,
        ST_WIN     = WIN
    } tug_state_e;

    function automatic int unsigned centre_pos(input int unsigned n_pos);
        return (n_pos - 32'd1) / 32'd2;
    endfunction

endpackage

// File: rtl/tug_holdoff_timer.sv
// Quiet-period timer: counts consecutive idle cycles while enabled and
// restarts on any button activity; done marks the final idle cycle.
module tug_holdoff_timer #(
    parameter int unsigned HOLDOFF_CYC = 32'd16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic activity,
    output logic done
);

    localparam int unsigned CNT_W = (HOLDOFF_CYC > 32'd1) ? $clog2(HOLDOFF_CYC) : 32'd1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLDOFF_CYC - 32'd1);

    logic [CNT_W-1:0] count_r;
    logic             done_s;

    assign done_s = enable && !activity && (count_r == LAST);
    assign done   = done_s;

    // Idle-cycle counter; parks at zero whenever the controller is not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (!enable || activity || done_s) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tug_rope_ctrl.sv
// Tug-of-war game controller: moves the rope marker per won press, detects
// wins at either end, keeps saturating scores and gates the arbiter clear.
module tug_rope_ctrl
    import tug_pkg::*;
#(
    parameter int unsigned N_POS       = 32'd9,
    parameter int unsigned HOLDOFF_CYC = 32'd16,
    parameter int unsigned SCORE_W     = SCORE_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               tie,
    input  logic               right,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               start,
    output logic               clear,
    output logic [N_POS-1:0]   leds,
    output logic               win_l,
    output logic               win_r,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r
);

    localparam int unsigned        POS_W     = $clog2(N_POS);
    localparam logic [POS_W-1:0]   POS_CTR   = POS_W'(centre_pos(N_POS));
    localparam logic [POS_W-1:0]   POS_END   = POS_W'(N_POS - 32'd1);
    localparam logic [POS_W-1:0]   POS_ZERO  = {POS_W{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    function automatic logic [N_POS-1:0] pos_onehot(input logic [POS_W-1:0] p);
        pos_onehot = {{(N_POS-1){1'b0}}, 1'b1} << p;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (v == SCORE_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + SCORE_W'(1);
        end
    endfunction

    logic [1:0]         state_r, state_s;
    logic [POS_W-1:0]   pos_r, pos_s;
    logic               win_l_r, win_l_s, win_r_r, win_r_s;
    logic [SCORE_W-1:0] score_l_r, score_l_s, score_r_r, score_r_s;
    logic [N_POS-1:0]   leds_r;
    logic               clear_r;
    logic               btn_any_s;
    logic               holdoff_done_s;

    assign btn_any_s = btn_l | btn_r;

    tug_holdoff_timer #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_holdoff (
        .clk      (clk),
        .rst_n    (rst),
        .enable   (state_r == HOLDOFF),
        .activity (btn_any_s),
        .done     (holdoff_done_s)
    );

    // Next-state, rope position, win flags and score update.
    always_comb begin
        state_s   = state_r;
        pos_s     = pos_r;
        win_l_s   = win_l_r;
        win_r_s   = win_r_r;
        score_l_s = score_l_r;
        score_r_s = score_r_r;
        case (state_r)
            HOLDOFF: begin
                if (holdoff_done_s) begin
                    state_s = ARMED;
                end else begin
                    state_s = HOLDOFF;
                end
            end
            ARMED: begin
                if (tie) begin
                    state_s = RELEASE;
                end else if (push) begin
                    if (right) begin
                        pos_s = pos_r + POS_W'(1);
                    end else begin
                        pos_s = pos_r - POS_W'(1);
                    end
                    // An end position always goes to WIN before any further move.
                    if (pos_s == POS_END) begin
                        state_s   = WIN;
                        win_r_s   = 1'b1;
                        score_r_s = sat_inc(score_r_r);
                    end else if (pos_s == POS_ZERO) begin
                        state_s   = WIN;
                        win_l_s   = 1'b1;
                        score_l_s = sat_inc(score_l_r);
                    end else begin
                        state_s = RELEASE;
                    end
                end else begin
                    state_s = ARMED;
                end
            end
            RELEASE: begin
                if (!btn_any_s) begin
                    state_s = HOLDOFF;
                end else begin
                    state_s = RELEASE;
                end
            end
            WIN: begin
                if (start) begin
                    state_s = HOLDOFF;
                    pos_s   = POS_CTR;
                    win_l_s = 1'b0;
                    win_r_s = 1'b0;
                end else begin
                    state_s = WIN;
                end
            end
            default: begin
                state_s = HOLDOFF;
                pos_s   = POS_CTR;
            end
        endcase
    end

    // State and registered outputs; clear is decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= HOLDOFF;
            pos_r     <= POS_CTR;
            leds_r    <= pos_onehot(POS_CTR);
            clear_r   <= 1'b1;
            win_l_r   <= 1'b0;
            win_r_r   <= 1'b0;
            score_l_r <= {SCORE_W{1'b0}};
            score_r_r <= {SCORE_W{1'b0}};
        end else begin
            state_r   <= state_s;
            pos_r     <= pos_s;
            leds_r    <= pos_onehot(pos_s);
            clear_r   <= (state_s != ARMED);
            win_l_r   <= win_l_s;
            win_r_r   <= win_r_s;
            score_l_r <= score_l_s;
            score_r_r <= score_r_s;
        end
    end

    assign clear   = clear_r;
    assign leds    = leds_r;
    assign win_l   = win_l_r;
    assign win_r   = win_r_r;
    assign score_l = score_l_r;
    assign score_r = score_r_r;

endmodule

// File: tb/tb_tug_rope_ctrl.sv
// Scoreboard bench for tug_rope_ctrl: stimulus queues hand-derived expected
// outputs per cycle, an independent monitor pops and compares them.
module tb_tug_rope_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0, tie = 1'b0, right = 1'b0;
    logic       btn_l = 1'b0, btn_r = 1'b0, start = 1'b0;
    logic       clear, win_l, win_r;
    logic [8:0] leds;
    logic [3:0] score_l, score_r;

    tug_rope_ctrl #(.N_POS(9), .HOLDOFF_CYC(16), .SCORE_W(4)) dut (
        .clk(clk), .rst(rst), .push(push), .tie(tie), .right(right),
        .btn_l(btn_l), .btn_r(btn_r), .start(start), .clear(clear),
        .leds(leds), .win_l(win_l), .win_r(win_r),
        .score_l(score_l), .score_r(score_r)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] leds;
        logic       clear;
        logic       wl;
        logic       wr;
        logic [3:0] sl;
        logic [3:0] sr;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    event  chk_ev;

    int         e_pos = 4;
    logic       e_clear = 1'b1, e_wl = 1'b0, e_wr = 1'b0;
    logic [3:0] e_sl = 4'd0, e_sr = 4'd0;
    logic [8:0] one9 = 9'd1;

    function automatic snap_t cur_exp();
        snap_t s;
        s.leds  = one9 << e_pos;
        s.clear = e_clear;
        s.wl    = e_wl;
        s.wr    = e_wr;
        s.sl    = e_sl;
        s.sr    = e_sr;
        return s;
    endfunction

    task automatic expect_now(input string tag);
        exp_q.push_back(cur_exp());
        tag_q.push_back(tag);
    endtask

    task automatic step(input string tag, input logic p, input logic t, input logic r,
                        input logic bl, input logic br, input logic s);
        @(negedge clk);
        push = p; tie = t; right = r; btn_l = bl; btn_r = br; start = s;
        expect_now(tag);
    endtask

    // HOLDOFF entered with count 0: fifteen idle cycles keep clear, the sixteenth arms.
    task automatic arm(input string tag);
        e_clear = 1'b1;
        repeat (15) step(tag, 0, 0, 0, 0, 0, 0);
        e_clear = 1'b0;
        step({tag, "_armed"}, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic press(input string tag, input logic rgt, input int hold);
        bit won;
        e_pos   = rgt ? e_pos + 1 : e_pos - 1;
        e_clear = 1'b1;
        won     = (e_pos == 8) || (e_pos == 0);
        if (e_pos == 8) begin
            e_wr = 1'b1;
            if (e_sr != 4'd15) e_sr = e_sr + 4'd1;
        end else if (e_pos == 0) begin
            e_wl = 1'b1;
            if (e_sl != 4'd15) e_sl = e_sl + 4'd1;
        end
        step(tag, 1, 0, rgt, !rgt, rgt, 0);
        repeat (hold) step({tag, "_hold"}, 0, 0, 0, !rgt, rgt, 0);
        step({tag, "_rel"}, 0, 0, 0, 0, 0, 0);
        if (!won) arm({tag, "_ho"});
    endtask

    task automatic new_round(input string tag);
        e_pos = 4; e_wl = 1'b0; e_wr = 1'b0; e_clear = 1'b1;
        step(tag, 0, 0, 0, 0, 0, 1);
        arm({tag, "_ho"});
    endtask

    // Monitor: compare one queued expectation after each clock edge or on demand.
    initial begin
        snap_t e, a;
        string tg;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                a  = {leds, clear, win_l, win_r, score_l, score_r};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got leds=%b clear=%b wl=%b wr=%b sl=%0d sr=%0d, want leds=%b clear=%b wl=%b wr=%b sl=%0d sr=%0d",
                             tg, a.leds, a.clear, a.wl, a.wr, a.sl, a.sr,
                             e.leds, e.clear, e.wl, e.wr, e.sl, e.sr);
                end
            end
        end
    end

    initial begin
        // Reset values while rst is held low.
        repeat (2) step("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        arm("t1_holdoff");

        // Idle and a stray start leave ARMED untouched.
        step("armed_idle", 0, 0, 0, 0, 0, 0);
        step("start_ignored", 0, 0, 0, 0, 0, 1);

        // Right press with btn_r held for ten cycles, then back to centre.
        press("t2_right", 1'b1, 9);
        press("t2_left", 1'b0, 0);

        // Four right wins from centre reach the right end.
        for (int i = 0; i < 4; i++) press("t3_right", 1'b1, 0);
        step("win_push_ignored", 1, 0, 0, 1, 0, 0);
        step("win_idle", 0, 0, 0, 0, 0, 0);
        new_round("t3_start");

        // Tie, then tie together with push: no move, back through HOLDOFF.
        e_clear = 1'b1;
        step("t4_tie", 0, 1, 0, 1, 1, 0);
        step("t4_tie_rel", 0, 0, 0, 0, 0, 0);
        arm("t4_ho");
        e_clear = 1'b1;
        step("t4_tie_push", 1, 1, 1, 1, 1, 0);
        step("t4_tp_rel", 0, 0, 0, 0, 0, 0);

        // Button activity during HOLDOFF restarts the quiet period.
        repeat (10) step("t5_idle", 0, 0, 0, 0, 0, 0);
        step("t5_pulse", 0, 0, 0, 1, 0, 0);
        arm("t5_ho");

        // Sixteen left rounds: score_l saturates at 15.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 4; i++) press("t6_left", 1'b0, 0);
            new_round("t6_start");
        end

        // Move to position 2, then async reset while still in RELEASE.
        press("t6_l3", 1'b0, 0);
        e_pos = 2; e_clear = 1'b1;
        step("t6_to2", 1, 0, 0, 1, 0, 0);
        @(negedge clk);
        push = 1'b0;
        #2 rst = 1'b0;
        e_pos = 4; e_clear = 1'b1; e_wl = 1'b0; e_wr = 1'b0; e_sl = 4'd0; e_sr = 4'd0;
        expect_now("async_rst");
        -> chk_ev;
        @(posedge clk);
        #2 rst = 1'b1; btn_l = 1'b0;
        arm("t6_rearm");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
